// File: rtl/sl_receiver_if.sv
// sl_receiver_if: peripheral-bus register port of the SL receiver.
//   d_in   - register write data (driven by the bus master)
//   wr_en  - write strobe (driven by the bus master)
//   addr   - 0 = DATA, 1 = CTRL/STATUS (driven by the bus master)
//   d_out  - register read data, combinational on addr (driven by the receiver)
//   irq    - interrupt request, mirrors READY (driven by the receiver)
interface sl_receiver_if;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic        wr_en;
  logic        addr;
  logic        irq;

  modport master (
    output d_in,
    output wr_en,
    output addr,
    input  d_out,
    input  irq
  );

  modport slave (
    input  d_in,
    input  wr_en,
    input  addr,
    output d_out,
    output irq
  );
endinterface

// File: rtl/sl_receiver.sv
// sl_receiver: far end of the two-wire SL link. Decodes idle-high SL0/SL1
// low-phase symbols into a word, checks payload length and odd parity, and
// exposes the result through a two-address register file.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   sl0  - SL line 0, asynchronous, idle high
//   sl1  - SL line 1, asynchronous, idle high
//   bus  - register port (d_in, wr_en, addr in; d_out, irq out)
// SYNC_STAGES must be at least 2.
module sl_receiver #(
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_BASE = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sl0,
  input  logic         sl1,
  sl_receiver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync0_q, sync0_d;
  logic [SYNC_STAGES-1:0] sync1_q, sync1_d;
  logic [1:0]             mask_q, mask_d;
  logic [32:0]            shift_q, shift_d;
  logic [5:0]             count_q, count_d;
  logic [15:0]            to_cnt_q, to_cnt_d;
  logic [31:0]            data_q, data_d;
  logic [5:0]             cfg_len_q, cfg_len_d;
  logic [5:0]             last_len_q, last_len_d;
  logic [2:0]             freq_q, freq_d;
  logic                   ready_q, ready_d;
  logic                   par_err_q, par_err_d;
  logic                   len_err_q, len_err_d;
  logic                   ovr_q, ovr_d;
  logic                   tmo_q, tmo_d;

  logic        s0, s1;
  logic        any_low;
  logic        sym_end;
  logic        line_chg;
  logic        wr_ctrl;
  logic        busy;
  logic [15:0] to_limit;
  logic [31:0] status;
  logic        unused_bits;

  assign s0       = sync0_q[SYNC_STAGES-1];
  assign s1       = sync1_q[SYNC_STAGES-1];
  assign any_low  = !s0 || !s1;
  // A symbol ends on the first both-high cycle after a low phase.
  assign sym_end  = !any_low && (mask_q != 2'b00);
  // Compare the last stage with its input so the timeout counter restarts
  // on the same edge the synchronized line actually changes.
  assign line_chg = (sync0_q[SYNC_STAGES-2] != s0) || (sync1_q[SYNC_STAGES-2] != s1);
  assign wr_ctrl  = bus.wr_en && bus.addr;
  assign busy     = (state_q != IDLE);
  assign to_limit = 16'(TIMEOUT_BASE) << freq_q;

  assign status = {3'b000, tmo_q, ovr_q, len_err_q, par_err_q, ready_q,
                   7'b0000000, busy, last_len_q, freq_q, 1'b0, cfg_len_q};

  assign bus.d_out = bus.addr ? status : data_q;
  assign bus.irq   = ready_q;

  assign unused_bits = ^{bus.d_in[31:29], bus.d_in[23:10], bus.d_in[6]};

  always_comb begin
    sync0_d    = {sync0_q[SYNC_STAGES-2:0], sl0};
    sync1_d    = {sync1_q[SYNC_STAGES-2:0], sl1};
    mask_d     = any_low ? (mask_q | {!s1, !s0}) : 2'b00;
    to_cnt_d   = line_chg ? 16'd0 :
                 ((to_cnt_q == 16'hFFFF) ? to_cnt_q : to_cnt_q + 16'd1);
    state_d    = state_q;
    shift_d    = shift_q;
    count_d    = count_q;
    data_d     = data_q;
    last_len_d = last_len_q;
    cfg_len_d  = cfg_len_q;
    freq_d     = freq_q;
    ready_d    = ready_q;
    par_err_d  = par_err_q;
    len_err_d  = len_err_q;
    ovr_d      = ovr_q;
    tmo_d      = tmo_q;

    // Register writes come first so that flag sets below override a
    // same-cycle write-0 clear.
    if (wr_ctrl) begin
      cfg_len_d = bus.d_in[5:0];
      freq_d    = bus.d_in[9:7];
      ready_d   = ready_q   & bus.d_in[24];
      par_err_d = par_err_q & bus.d_in[25];
      len_err_d = len_err_q & bus.d_in[26];
      ovr_d     = ovr_q     & bus.d_in[27];
      tmo_d     = tmo_q     & bus.d_in[28];
    end

    case (state_q)
      IDLE: begin
        // mask 01 = bit 0, 10 = bit 1; bit value is mask[1]. STOP ignored.
        if (sym_end && (mask_q != 2'b11)) begin
          state_d = RECV;
          shift_d = {32'd0, mask_q[1]};
          count_d = 6'd1;
        end
      end
      RECV: begin
        if (sym_end) begin
          if (mask_q == 2'b11) begin
            state_d = IDLE;
            // shift_q holds payload then parity, right-aligned, zero above.
            if ((count_q - 6'd1) != cfg_len_q) len_err_d = 1'b1;
            if (!(^shift_q))                   par_err_d = 1'b1;
            if (((count_q - 6'd1) == cfg_len_q) && (^shift_q)) begin
              data_d     = shift_q[32:1];
              last_len_d = count_q - 6'd1;
              ready_d    = 1'b1;
              if (ready_q) ovr_d = 1'b1;
            end
          end else if (count_q == 6'd33) begin
            len_err_d = 1'b1;
            state_d   = DRAIN;
          end else begin
            shift_d = {shift_q[31:0], mask_q[1]};
            count_d = count_q + 6'd1;
          end
        end else if (to_cnt_d == to_limit) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (sym_end) begin
          if (mask_q == 2'b11) state_d = IDLE;
        end else if (to_cnt_d == to_limit) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // Frame shift register is overwritten at frame start; no reset needed.
    shift_q <= shift_d;
    if (rst) begin
      state_q    <= IDLE;
      sync0_q    <= '1;
      sync1_q    <= '1;
      mask_q     <= 2'b00;
      count_q    <= 6'd0;
      to_cnt_q   <= 16'd0;
      data_q     <= 32'd0;
      cfg_len_q  <= 6'd8;
      last_len_q <= 6'd0;
      freq_q     <= 3'd0;
      ready_q    <= 1'b0;
      par_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
      ovr_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync0_q    <= sync0_d;
      sync1_q    <= sync1_d;
      mask_q     <= mask_d;
      count_q    <= count_d;
      to_cnt_q   <= to_cnt_d;
      data_q     <= data_d;
      cfg_len_q  <= cfg_len_d;
      last_len_q <= last_len_d;
      freq_q     <= freq_d;
      ready_q    <= ready_d;
      par_err_q  <= par_err_d;
      len_err_q  <= len_err_d;
      ovr_q      <= ovr_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule

// File: tb/tb_sl_receiver.sv
// tb_sl_receiver: directed bench for sl_receiver. Drives SL symbols on the
// raw lines and reads the register file through the bus interface.
module tb_sl_receiver;
  logic clk = 1'b0;
  logic rst;
  logic sl0;
  logic sl1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sl_receiver_if bus ();

  sl_receiver #(
    .SYNC_STAGES (2),
    .TIMEOUT_BASE(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sl0(sl0),
    .sl1(sl1),
    .bus(bus)
  );

  task automatic rd(input logic a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.d_out;
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    @(negedge clk);
    bus.addr  = a;
    bus.d_in  = d;
    bus.wr_en = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
  endtask

  // lo0/lo1 select which lines go low during the symbol's low phase.
  task automatic sym(input logic lo0, input logic lo1);
    @(posedge clk);
    #1;
    sl0 = !lo0;
    sl1 = !lo1;
    repeat (3) @(posedge clk);
    #1;
    sl0 = 1'b1;
    sl1 = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    sym(!b, b);
  endtask

  task automatic send_word(input logic [31:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic [31:0] d, input int n, input logic par);
    send_word(d, n);
    send_bit(par);
    sym(1'b1, 1'b1);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; sl0 = 1'b1; sl1 = 1'b1;
    bus.wr_en = 1'b0; bus.addr = 1'b0; bus.d_in = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0000_0008) begin failures++; $display("FAIL reset_status got=%h exp=%h", v, 32'h8); end
    rd(1'b0, v);
    checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", v, 32'h0); end
    checks++;
    if (bus.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
  endtask

  task automatic test_basic();
    logic [31:0] v;
    send_word(32'hA5, 8);
    send_bit(1'b1);
    // STOP inline to check the exact READY latency.
    @(posedge clk); #1; sl0 = 1'b0; sl1 = 1'b0;
    repeat (3) @(posedge clk); #1; sl0 = 1'b1; sl1 = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (bus.irq !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", bus.irq); end
    @(posedge clk); #1;
    checks++;
    if (bus.irq !== 1'b1) begin failures++; $display("FAIL latency_irq got=%b exp=1", bus.irq); end
    rd(1'b0, v);
    checks++;
    if (v !== 32'h0000_00A5) begin failures++; $display("FAIL basic_data got=%h exp=%h", v, 32'hA5); end
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0100_2008) begin failures++; $display("FAIL basic_status got=%h exp=%h", v, 32'h01002008); end
    wr(1'b0, 32'hFFFF_FFFF);
    rd(1'b0, v);
    checks++;
    if (v !== 32'h0000_00A5) begin failures++; $display("FAIL data_ro got=%h exp=%h", v, 32'hA5); end
    wr(1'b1, 32'h0000_0008);
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0000_2008) begin failures++; $display("FAIL ready_clear got=%h exp=%h", v, 32'h2008); end
    checks++;
    if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", bus.irq); end
  endtask

  task automatic test_par_err();
    logic [31:0] v;
    wr(1'b1, 32'h0000_0020);
    // 0xDEADBEEF has 24 ones; parity 0 makes the total even.
    send_frame(32'hDEAD_BEEF, 32, 1'b0);
    #1;
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0200_2020) begin failures++; $display("FAIL par_status got=%h exp=%h", v, 32'h02002020); end
    rd(1'b0, v);
    checks++;
    if (v !== 32'h0000_00A5) begin failures++; $display("FAIL par_data got=%h exp=%h", v, 32'hA5); end
    wr(1'b1, 32'h0000_0008);
  endtask

  task automatic test_len_err();
    logic [31:0] v;
    send_frame(32'h0000_03E0, 10, 1'b0);
    #1;
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0400_2008) begin failures++; $display("FAIL len_short_status got=%h exp=%h", v, 32'h04002008); end
    wr(1'b1, 32'h0000_0008);
    for (int i = 0; i < 40; i++) send_bit(i[0]);
    #1;
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0401_2008) begin failures++; $display("FAIL len_long_busy got=%h exp=%h", v, 32'h04012008); end
    sym(1'b1, 1'b1);
    #1;
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0400_2008) begin failures++; $display("FAIL len_long_done got=%h exp=%h", v, 32'h04002008); end
    rd(1'b0, v);
    checks++;
    if (v !== 32'h0000_00A5) begin failures++; $display("FAIL len_data got=%h exp=%h", v, 32'hA5); end
    wr(1'b1, 32'h0000_0008);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    send_frame(32'h3C, 8, 1'b1);
    #1;
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0100_2008) begin failures++; $display("FAIL b2b_first got=%h exp=%h", v, 32'h01002008); end
    send_word(32'h81, 8);
    send_bit(1'b1);
    // Skewed STOP: sl1 falls and rises one cycle after sl0.
    @(posedge clk); #1; sl0 = 1'b0;
    @(posedge clk); #1; sl1 = 1'b0;
    repeat (2) @(posedge clk); #1; sl0 = 1'b1;
    @(posedge clk); #1; sl1 = 1'b1;
    repeat (3) @(posedge clk); #1;
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0900_2008) begin failures++; $display("FAIL overrun_status got=%h exp=%h", v, 32'h09002008); end
    rd(1'b0, v);
    checks++;
    if (v !== 32'h0000_0081) begin failures++; $display("FAIL overrun_data got=%h exp=%h", v, 32'h81); end
    wr(1'b1, 32'h0000_0008);
    // Clear write lands on the same edge READY gets set.
    send_word(32'h7F, 8);
    send_bit(1'b0);
    @(posedge clk); #1; sl0 = 1'b0; sl1 = 1'b0;
    repeat (3) @(posedge clk); #1; sl0 = 1'b1; sl1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.addr = 1'b1; bus.d_in = 32'h0000_0008; bus.wr_en = 1'b1;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0100_2008) begin failures++; $display("FAIL set_wins got=%h exp=%h", v, 32'h01002008); end
    rd(1'b0, v);
    checks++;
    if (v !== 32'h0000_007F) begin failures++; $display("FAIL set_wins_data got=%h exp=%h", v, 32'h7F); end
    wr(1'b1, 32'h0100_0008);
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0100_2008) begin failures++; $display("FAIL write1_keeps got=%h exp=%h", v, 32'h01002008); end
    wr(1'b1, 32'h0000_0008);
  endtask

  task automatic test_timeout();
    logic [31:0] v;
    wr(1'b1, 32'h0000_0108);
    // Last synchronized change is 1 edge before the send task returns.
    send_word(32'h16, 5);
    repeat (254) @(posedge clk);
    #1;
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0001_2108) begin failures++; $display("FAIL timeout_early got=%h exp=%h", v, 32'h00012108); end
    @(posedge clk); #1;
    rd(1'b1, v);
    checks++;
    if (v !== 32'h1000_2108) begin failures++; $display("FAIL timeout_fire got=%h exp=%h", v, 32'h10002108); end
    rd(1'b0, v);
    checks++;
    if (v !== 32'h0000_007F) begin failures++; $display("FAIL timeout_data got=%h exp=%h", v, 32'h7F); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    send_word(32'h5, 3);
    #1;
    rd(1'b1, v);
    checks++;
    if (v !== 32'h1001_2108) begin failures++; $display("FAIL midframe_busy got=%h exp=%h", v, 32'h10012108); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0000_0008) begin failures++; $display("FAIL midreset_status got=%h exp=%h", v, 32'h8); end
    rd(1'b0, v);
    checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL midreset_data got=%h exp=%h", v, 32'h0); end
    send_frame(32'hA5, 8, 1'b1);
    #1;
    rd(1'b0, v);
    checks++;
    if (v !== 32'h0000_00A5) begin failures++; $display("FAIL postreset_data got=%h exp=%h", v, 32'hA5); end
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0100_2008) begin failures++; $display("FAIL postreset_status got=%h exp=%h", v, 32'h01002008); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_par_err();
    test_len_err();
    test_back_to_back();
    test_timeout();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
